// File: rtl/smaesh_out_serializer_pkg.sv
// Shared widths and helpers for the SMAESH ciphertext output serializer.
// Blocks are split into 32-bit words share by share, least significant word first.
package smaesh_out_serializer_pkg;

  localparam int SMAESH_WORD_W          = 32;
  localparam int SMAESH_BLK_W           = 128;
  localparam int SMAESH_WORDS_PER_SHARE = 4;

  function automatic int words_per_block(input int d);
    return SMAESH_WORDS_PER_SHARE * d;
  endfunction

endpackage

// File: rtl/smaesh_sh_word_mux.sv
// Combinational word selector: picks word wcnt of a shared block and its share index.
// The word is forced to zero when nothing is buffered, so idle output is clean.
module smaesh_sh_word_mux
  import smaesh_out_serializer_pkg::*;
#(
  parameter int D       = 2,
  parameter int SHIDX_W = 4,
  parameter int WCNT_W  = $clog2(words_per_block(D))
) (
  input  logic [SMAESH_BLK_W*D-1:0] blk_i,
  input  logic [WCNT_W-1:0]         wcnt_i,
  input  logic                      en_i,
  output logic [SMAESH_WORD_W-1:0]  word_o,
  output logic [SHIDX_W-1:0]        share_idx_o
);

  localparam int NW = words_per_block(D);

  logic [SMAESH_WORD_W-1:0] words [NW];

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_words
      assign words[gi] = blk_i[SMAESH_WORD_W*gi +: SMAESH_WORD_W];
    end
  endgenerate

  always_comb begin
    word_o      = en_i ? words[wcnt_i] : '0;
    share_idx_o = SHIDX_W'(wcnt_i >> 2);
  end

endmodule

// File: rtl/smaesh_out_serializer.sv
// Two-slot block buffer that drains masked AES ciphertext as 32-bit words.
// in_ready depends only on registered occupancy, never on out_ready.
module smaesh_out_serializer
  import smaesh_out_serializer_pkg::*;
#(
  parameter int d       = 2,
  parameter int SHIDX_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SMAESH_BLK_W*d-1:0] in_shares_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SMAESH_WORD_W-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [SHIDX_W-1:0]        out_share_idx,
  output logic                      busy
);

  localparam int NW     = words_per_block(d);
  localparam int WCNT_W = $clog2(NW);
  localparam int BW     = SMAESH_BLK_W * d;

  logic [BW-1:0]     slot_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              accept, pop, release_blk;

  assign in_ready    = (cnt_q != 2'd2);
  assign out_valid   = (cnt_q != 2'd0);
  assign busy        = out_valid;
  assign accept      = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign release_blk = pop & (wcnt_q == WCNT_W'(NW - 1));
  assign out_last    = out_valid & (wcnt_q == WCNT_W'(NW - 1));

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, release_blk})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    wcnt_d = wcnt_q;
    if (release_blk)
      wcnt_d = '0;
    else if (pop)
      wcnt_d = wcnt_q + WCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      wcnt_q   <= '0;
    end else begin
      if (accept)      wr_ptr_q <= ~wr_ptr_q;
      if (release_blk) rd_ptr_q <= ~rd_ptr_q;
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  // At cnt==1 the write and read pointers differ, so a same-edge accept and release never collide.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          slot_q[gi] <= '0;
        else if (accept && (wr_ptr_q == 1'(gi)))
          slot_q[gi] <= in_shares_data;
        else if (release_blk && (rd_ptr_q == 1'(gi)))
          slot_q[gi] <= '0;
      end
    end
  endgenerate

  smaesh_sh_word_mux #(
    .D       (d),
    .SHIDX_W (SHIDX_W),
    .WCNT_W  (WCNT_W)
  ) u_mux (
    .blk_i       (slot_q[rd_ptr_q]),
    .wcnt_i      (wcnt_q),
    .en_i        (out_valid),
    .word_o      (out_data),
    .share_idx_o (out_share_idx)
  );

endmodule

// File: tb/tb_smaesh_out_serializer.sv
// Self-checking bench: a word-queue model of the serializer checked every cycle,
// plus directed literal checks for the d=2 and d=1 configurations.
module tb_smaesh_out_serializer;

  localparam int D  = 2;
  localparam int NW = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] in_data;
  logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0]  out_data;
  logic [3:0]   out_share_idx;

  logic [127:0] c1_in_data;
  logic         c1_in_valid, c1_in_ready, c1_out_valid, c1_out_ready, c1_out_last, c1_busy;
  logic [31:0]  c1_out_data;
  logic [3:0]   c1_out_share_idx;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  smaesh_out_serializer #(.d(D), .SHIDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_shares_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_share_idx(out_share_idx),
    .busy(busy)
  );

  smaesh_out_serializer #(.d(1), .SHIDX_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_shares_data(c1_in_data), .in_valid(c1_in_valid),
    .in_ready(c1_in_ready), .out_data(c1_out_data), .out_valid(c1_out_valid),
    .out_ready(c1_out_ready), .out_last(c1_out_last), .out_share_idx(c1_out_share_idx),
    .busy(c1_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted block becomes NW queued words; a handshake pops one.
  always @(negedge clk) begin
    int blocks;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_share_idx", out_share_idx, 0);
      chk("rst_out_data", out_data, 0);
      mq.delete();
    end else begin
      blocks = (mq.size() + NW - 1) / NW;
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, blocks < 2);
      chk("busy", busy, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0].w);
        chk("share_idx", out_share_idx, mq[0].idx);
        chk("out_last", out_last, mq[0].last);
      end else begin
        chk("idle_data", out_data, 0);
        chk("idle_last", out_last, 0);
      end
      if (mq.size() != 0 && out_ready) begin
        got_q.push_back(out_data);
        void'(mq.pop_front());
      end
      if (in_valid && blocks < 2) begin
        for (int k = 0; k < NW; k++) begin
          exp_t e;
          e.w    = in_data[32*k +: 32];
          e.idx  = 4'(k / 4);
          e.last = (k == NW - 1);
          mq.push_back(e);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic logic [255:0] rnd_blk();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Stimulus always resumes at posedge+1 so inputs are stable across the next negedge.
  task automatic send_block(input logic [255:0] data);
    in_data  = data;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 600; t++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 1, 0);
  endtask

  initial begin
    logic [31:0] exp_words [8];
    logic [31:0] exp_c1 [4];
    int k;
    exp_words = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233,
                  32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    exp_c1    = '{32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    c1_in_valid = 1'b0; c1_in_data = '0; c1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed d=2 block: share0 in the low 128 bits, share1 in the high.
    got_q.delete();
    send_block({128'h0F0E0D0C_0B0A0908_07060504_03020100,
                128'h00112233_44556677_8899AABB_CCDDEEFF});
    wait_drain();
    chk("lit_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk($sformatf("lit_word%0d", i), got_q[i], exp_words[i]);

    // Directed d=1 block.
    c1_in_data  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    c1_in_valid = 1'b1;
    @(posedge clk); #1;
    c1_in_valid = 1'b0;
    k = 0;
    for (int t = 0; t < 20 && k < 4; t++) begin
      @(negedge clk);
      if (t == 0) chk("d1_latency", c1_out_valid, 1);
      if (c1_out_valid) begin
        chk($sformatf("d1_word%0d", k), c1_out_data, exp_c1[k]);
        chk("d1_share_idx", c1_out_share_idx, 0);
        chk("d1_last", c1_out_last, k == 3);
        k++;
      end
    end
    chk("d1_word_count", k, 4);
    @(posedge clk); #1;

    // Fill with out_ready low: third block must be held off.
    mode = 1;
    @(posedge clk); #1;
    send_block(rnd_blk());
    send_block(rnd_blk());
    in_data = rnd_blk(); in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    mode = 0;
    send_block(in_data);
    wait_drain();

    // Toggling out_ready.
    mode = 2;
    for (int i = 0; i < 3; i++) send_block(rnd_blk());
    wait_drain();

    // Accept lands on the edge of the final pop of the previous block.
    mode = 0;
    @(posedge clk); #1;
    send_block(rnd_blk());
    repeat (7) @(posedge clk);
    #1;
    send_block(rnd_blk());
    wait_drain();

    // Random traffic.
    mode = 3;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_block(rnd_blk());
    end
    wait_drain();

    // Asynchronous reset mid-block at wcnt==3.
    mode = 0;
    @(posedge clk); #1;
    send_block(rnd_blk());
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    send_block(rnd_blk());
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smaesh_out_serializer.md
Name: smaesh_out_serializer

Overview:
- Consumer ("reader") end of the core's 128*d-bit ciphertext valid/ready output stream.
- Takes one complete shared ciphertext block per handshake and stores it in a 2-slot buffer, so the core is never stalled by a single slow word read.
- Emits the block as 32-bit words over a valid/ready stream, share by share, tagging the last word.
- Sits between the masked AES top and a 32-bit host bus / DMA.

Parameters:
- d, 2, number of shares (d >= 1).
- SHIDX_W, 4, width of out_share_idx; requires 2^SHIDX_W >= d.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_shares_data  input  128*d  ciphertext shares; share i at bits [128*i +: 128].
- in_valid  input  1  block available from core.
- in_ready  output  1  block slot free.
- out_data  output  32  current word.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  current word is the final word of the block.
- out_share_idx  output  SHIDX_W  share index of the current word.
- busy  output  1  at least one block is buffered.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Outputs: out_valid=0, in_ready=1, busy=0, out_last=0, out_share_idx=0, out_data=0.
  - State: both slots cleared to 0, pointers, count and word counter cleared to 0.
- State:
  - slot[0..1] are 128*d-bit registers.
  - wr_ptr and rd_ptr are 1 bit each.
  - cnt is 0..2.
  - wcnt is 0..4d-1, word index within the block being read.
- in_ready = (cnt != 2). It is a pure function of registered state, with no combinational path from out_ready.
- Accept: when in_valid & in_ready, slot[wr_ptr] <= in_shares_data, then wr_ptr toggles.
- Word order:
  - word k = slot[rd_ptr][32*k +: 32] for k = 0..4d-1.
  - Share-major: words 0-3 are share 0 (LSW first), words 4-7 are share 1, and so on.
  - out_share_idx = wcnt/4.
- Outputs:
  - out_valid = (cnt != 0).
  - out_last = out_valid & (wcnt == 4d-1).
  - out_data and out_share_idx are combinational from rd_ptr and wcnt. Drive out_data to 0 when cnt == 0.
- Pop:
  - On out_valid & out_ready: if wcnt == 4d-1, wcnt wraps to 0, rd_ptr toggles and the block is released; otherwise wcnt increments.
  - A released slot is zeroed on the same edge, so no stale shares persist.
- cnt update:
  - +1 on accept without release.
  - -1 on release without accept.
  - Unchanged when both or neither occur.
  - Accept is impossible when cnt == 2, and release is impossible when cnt == 0.
- Latency: a block accepted at edge t drives out_valid at t+1 when the buffer was empty. With out_ready held high, throughput is 4d words per block.
- Back-to-back blocks: the word after out_last of block A is word 0 of block B in the next cycle, with no bubble when cnt was 2.
- Simultaneous accept and final pop at cnt == 1: the new block goes to the other slot, cnt stays 1, and reading continues from the new block.
- out_valid is held and out_data is stable until a handshake occurs (no retraction).
- busy = (cnt != 0).
- Reset mid-block: all buffered data is discarded and zeroed. No partial word is ever reissued.

Decomposition:
- Shared package:
  - SMAESH_WORD_W = 32.
  - SMAESH_BLK_W = 128.
  - SMAESH_WORDS_PER_SHARE = 4.
  - Function words_per_block(d) = 4*d.
- One sub-module is natural: smaesh_sh_word_mux (d). It is combinational and selects a 32-bit word and its share index from a 128*d block by wcnt.

Test Plan:
- d=2, reset, one block with share0=0x00112233_44556677_8899AABB_CCDDEEFF and share1=0x0F0E0D0C_0B0A0908_07060504_03020100, out_ready=1 -> 8 words: CCDDEEFF, 8899AABB, 44556677, 00112233, 03020100, 07060504, 0B0A0908, 0F0E0D0C. out_share_idx is 0,0,0,0,1,1,1,1. out_last is asserted only on the 8th word. out_valid rises one cycle after the accept.
- out_ready=0 with three blocks offered -> two accepted, in_ready=0, the third is held by the core. Release out_ready -> 24 words with no gaps; in_ready rises the cycle after the first out_last.
- out_ready toggled 1010... -> no word is duplicated or skipped, and out_data is stable whenever out_valid=1 and out_ready=0.
- cnt=1 with in_valid asserted in the same cycle as the final pop -> cnt stays 1, and the next word is the new block's word 0.
- rst_n asserted asynchronously mid-block (wcnt=3) -> out_valid drops immediately. After release, in_ready=1, busy=0, and the next block starts at word 0.
- d=1 -> 4 words per block, out_share_idx is always 0, and out_last is on the 4th word.
